exmem_arbiter: RTL and testbench



---
 rtl/exmem_arb_pkg.sv | 13 +
 rtl/rr_pick2.sv | 12 +
 rtl/exmem_arbiter.sv | 99 +++++++++
 tb/tb_exmem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exmem_arb_pkg.sv
// Shared encodings for the exmem arbiter: FSM state and port identifiers.
package exmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; on a tie the port that did not win last time is chosen.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);

   assign gnt_valid = |req;
   assign gnt_id    = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/exmem_arbiter.sv
// Shares the single exmem RAM port between the CPU and loader; one RAM access per grant,
// read data captured per port with a one-cycle done pulse.
module exmem_arbiter
   import exmem_arb_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int RAM_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     c_req,
   input  logic                     c_we,
   input  logic [RAM_ADDR_BITS-1:0] c_adr,
   input  logic [WIDTH-1:0]         c_wdata,
   output logic                     c_done,
   output logic [WIDTH-1:0]         c_rdata,
   input  logic                     l_req,
   input  logic                     l_we,
   input  logic [RAM_ADDR_BITS-1:0] l_adr,
   input  logic [WIDTH-1:0]         l_wdata,
   output logic                     l_done,
   output logic [WIDTH-1:0]         l_rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [RAM_ADDR_BITS-1:0] mem_adr,
   output logic [WIDTH-1:0]         mem_wdata,
   input  logic [WIDTH-1:0]         mem_rdata,
   output logic                     busy
);

   state_t state, state_nxt;
   logic   last;
   logic   gnt_q;
   logic   we_q;
   logic   gnt_valid, gnt_id;
   logic   c_done_q, l_done_q;

   rr_pick2 u_pick (
      .req       ({l_req, c_req}),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last      <= PORT_LDR;
         gnt_q     <= PORT_CPU;
         we_q      <= 1'b0;
         mem_adr   <= '0;
         mem_wdata <= '0;
         c_rdata   <= '0;
         l_rdata   <= '0;
         c_done_q  <= 1'b0;
         l_done_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         c_done_q <= 1'b0;
         l_done_q <= 1'b0;
         // Command is frozen at grant so later port changes cannot disturb the access.
         if (state == IDLE && gnt_valid) begin
            last      <= gnt_id;
            gnt_q     <= gnt_id;
            we_q      <= (gnt_id == PORT_LDR) ? l_we    : c_we;
            mem_adr   <= (gnt_id == PORT_LDR) ? l_adr   : c_adr;
            mem_wdata <= (gnt_id == PORT_LDR) ? l_wdata : c_wdata;
         end
         // RAM output is valid after its falling-edge access inside ISSUE.
         if (state == ISSUE) begin
            if (gnt_q == PORT_LDR) begin
               l_rdata  <= mem_rdata;
               l_done_q <= 1'b1;
            end else begin
               c_rdata  <= mem_rdata;
               c_done_q <= 1'b1;
            end
         end
      end
   end

   // Reset arriving during RESP must swallow the pulse that is already registered.
   assign c_done = c_done_q & ~reset;
   assign l_done = l_done_q & ~reset;
   assign mem_en = (state == ISSUE);
   assign mem_we = mem_en & we_q;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_exmem_arbiter.sv
// Directed bench for exmem_arbiter with a falling-edge read-before-write RAM model.
module tb_exmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_req, c_we, l_req, l_we;
   logic [7:0] c_adr, c_wdata, l_adr, l_wdata;
   logic       c_done, l_done;
   logic [7:0] c_rdata, l_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_adr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       busy;

   logic       ram_init;
   logic [7:0] ram [256];
   int         en_cnt = 0, cd_cnt = 0, ld_cnt = 0, both_cnt = 0, orphan_cnt = 0;
   int         total = 0, fails = 0;
   int         s_en, s_cd, s_ld;

   always #5 clk = ~clk;

   exmem_arbiter #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
      .c_done(c_done), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
      .l_done(l_done), .l_rdata(l_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   function automatic logic [7:0] init_val(input int a);
      case (a)
         8'h10:   return 8'hA5;
         8'h20:   return 8'h5A;
         8'h30:   return 8'h00;
         default: return 8'(a) ^ 8'hFF;
      endcase
   endfunction

   // RAM: falling-edge, read-before-write
   always @(negedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      end else if (mem_en) begin
         mem_rdata <= ram[mem_adr];
         if (mem_we) ram[mem_adr] <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (mem_en) en_cnt <= en_cnt + 1;
      if (c_done) cd_cnt <= cd_cnt + 1;
      if (l_done) ld_cnt <= ld_cnt + 1;
      if (c_done && l_done) both_cnt <= both_cnt + 1;
      if ((c_done || l_done) && !busy) orphan_cnt <= orphan_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; ram_init = 1'b1;
      c_req = 0; c_we = 0; c_adr = 0; c_wdata = 0;
      l_req = 0; l_we = 0; l_adr = 0; l_wdata = 0;
      repeat (3) step();
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", {30'd0, c_done, l_done}, 0);
      check("rst_rdata", {16'd0, c_rdata, l_rdata}, 0);
      check("rst_mem_cmd", {15'd0, mem_we, mem_adr, mem_wdata}, 0);
      reset = 1'b0; ram_init = 1'b0;
      step();

      // CPU-only read of 0x10
      s_en = en_cnt; s_ld = ld_cnt;
      c_adr = 8'h10; c_we = 0; c_req = 1;
      step();
      check("t1_issue_en", 32'(mem_en), 1);
      check("t1_issue_we", 32'(mem_we), 0);
      check("t1_issue_adr", 32'(mem_adr), 32'h10);
      check("t1_issue_busy", 32'(busy), 1);
      check("t1_issue_nodone", 32'(c_done), 0);
      step();
      check("t1_resp_en", 32'(mem_en), 0);
      check("t1_resp_cdone", 32'(c_done), 1);
      check("t1_resp_rdata", 32'(c_rdata), 32'hA5);
      check("t1_resp_ldone", 32'(l_done), 0);
      c_req = 0;
      step();
      check("t1_idle_cdone", 32'(c_done), 0);
      check("t1_idle_busy", 32'(busy), 0);
      step();
      check("t1_en_count", 32'(en_cnt - s_en), 1);
      check("t1_ldone_count", 32'(ld_cnt - s_ld), 0);

      // Loader write 0x20 <= 0x3C, old contents returned
      l_adr = 8'h20; l_we = 1; l_wdata = 8'h3C; l_req = 1;
      step();
      check("t2_issue_we", 32'(mem_we), 1);
      check("t2_issue_adr", 32'(mem_adr), 32'h20);
      check("t2_issue_wdata", 32'(mem_wdata), 32'h3C);
      step();
      check("t2_resp_ldone", 32'(l_done), 1);
      check("t2_resp_lrdata", 32'(l_rdata), 32'h5A);
      check("t2_resp_cdone", 32'(c_done), 0);
      l_req = 0; l_we = 0;
      step();
      check("t2_idle_we", 32'(mem_we), 0);
      check("t2_hold_adr", 32'(mem_adr), 32'h20);
      check("t2_hold_crdata", 32'(c_rdata), 32'hA5);
      check("t2_ram", 32'(ram[8'h20]), 32'h3C);
      c_adr = 8'h20; c_req = 1;
      step(); step();
      check("t2_cpu_done", 32'(c_done), 1);
      check("t2_cpu_rdata", 32'(c_rdata), 32'h3C);
      c_req = 0;
      step();

      // Simultaneous held requests after reset: CPU, LDR, CPU, LDR
      reset = 1; step(); reset = 0;
      c_adr = 8'h10; c_we = 0; l_adr = 8'h20; l_we = 0;
      c_req = 1; l_req = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3_grant_adr", 32'(mem_adr), (i % 2 == 0) ? 32'h10 : 32'h20);
         step();
         check("t3_cdone", 32'(c_done), (i % 2 == 0) ? 1 : 0);
         check("t3_ldone", 32'(l_done), (i % 2 == 0) ? 0 : 1);
         check("t3_rdata", 32'((i % 2 == 0) ? c_rdata : l_rdata), (i % 2 == 0) ? 32'hA5 : 32'h3C);
         if (i == 3) begin c_req = 0; l_req = 0; end
         step();
         check("t3_idle_nodone", {30'd0, c_done, l_done}, 0);
      end
      step();
      check("t3_no_extra", 32'(mem_en), 0);

      // Held req after done repeats the access; drop in IDLE stops it
      s_en = en_cnt; s_cd = cd_cnt;
      c_adr = 8'h10; c_req = 1;
      step(); step();
      check("t4_first_done", 32'(c_done), 1);
      step();
      step();
      check("t4_repeat_en", 32'(mem_en), 1);
      check("t4_repeat_adr", 32'(mem_adr), 32'h10);
      step();
      check("t4_second_done", 32'(c_done), 1);
      step();
      c_req = 0;
      step();
      check("t4_drop_en", 32'(mem_en), 0);
      check("t4_drop_busy", 32'(busy), 0);
      check("t4_en_count", 32'(en_cnt - s_en), 2);
      check("t4_done_count", 32'(cd_cnt - s_cd), 2);

      // Reset during ISSUE of loader write 0x30 <= 0x77
      s_ld = ld_cnt;
      l_adr = 8'h30; l_we = 1; l_wdata = 8'h77; l_req = 1;
      step();
      check("t5_in_issue", 32'(mem_en), 1);
      reset = 1; l_req = 0; l_we = 0;
      step();
      check("t5_rst_ldone", 32'(l_done), 0);
      check("t5_rst_busy", 32'(busy), 0);
      check("t5_rst_cmd", {14'd0, mem_en, mem_we, mem_adr, mem_wdata}, 0);
      check("t5_rst_rdata", {16'd0, c_rdata, l_rdata}, 0);
      reset = 0;
      step();
      check("t5_ldone_count", 32'(ld_cnt - s_ld), 0);
      c_adr = 8'h30; c_req = 1;
      step(); step();
      check("t5_persist", 32'(c_rdata), 32'h77);
      c_req = 0;
      step();

      // Reset during RESP of a CPU read
      s_cd = cd_cnt;
      c_adr = 8'h10; c_req = 1;
      step(); step();
      reset = 1; c_req = 0;
      #1;
      check("t6_resp_cdone", 32'(c_done), 0);
      step();
      check("t6_rst_rdata", 32'(c_rdata), 0);
      check("t6_rst_busy", 32'(busy), 0);
      reset = 0;
      step();
      check("t6_idle", {30'd0, busy, mem_en}, 0);
      check("t6_cdone_count", 32'(cd_cnt - s_cd), 0);

      check("excl_both_done", 32'(both_cnt), 0);
      check("excl_done_idle", 32'(orphan_cnt), 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed run still active expected finish");
      $fatal(1, "timeout");
   end

endmodule
